// File: rtl/crop_pkg.sv
// ----------------------------------------------------------------------------
// crop_pkg
// Shared definitions for the ROI crop stream block:
//   - crop_state_t : FSM encoding (IDLE / RUN / SKIP)
//   - cnt_width()  : bits needed to hold a count 0..max_count inclusive
//   - ROW_W/COL_W  : row/col counter widths for the default frame limits
// ----------------------------------------------------------------------------
package crop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // waiting for start of frame, non-SOF beats dropped
        RUN  = 2'd1,    // valid config, cropping into the output buffer
        SKIP = 2'd2     // invalid config, counting beats without output
    } crop_state_t;

    localparam int DEFAULT_MAX_ROWS = 1080;
    localparam int DEFAULT_MAX_COLS = 1920;

    // Width of a counter/config field able to represent 0..max_count.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

    localparam int ROW_W = cnt_width(DEFAULT_MAX_ROWS);
    localparam int COL_W = cnt_width(DEFAULT_MAX_COLS);

endpackage

// File: rtl/fifo_sync.sv
// ----------------------------------------------------------------------------
// fifo_sync
// Single-clock show-ahead FIFO. rd_data always presents the oldest entry
// while empty=0, so a beat written in one cycle is visible the next.
// Ports:
//   clk, reset (sync, active-low)
//   wr_en, wr_data, full   : write side (write accepted when not full, or
//                            when full and a read happens in the same cycle)
//   rd_en, rd_data, empty  : read side (read pops when not empty)
// ----------------------------------------------------------------------------
module fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]           wr_ptr_reg;
    logic [AW:0]           rd_ptr_reg;
    logic                  do_write;
    logic                  do_read;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_read  = rd_en && !empty;
    // When full, the slot being written is the one being read this cycle;
    // the read sees the old contents, the write lands at the clock edge.
    assign do_write = wr_en && (!full || do_read);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_write) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_read)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/crop_roi_stream.sv
// ----------------------------------------------------------------------------
// crop_roi_stream
// Crops a rectangular region of interest out of an AXI-stream video frame.
// Ports:
//   clk, reset (sync, active-low)
//   pixel_in_*   : input stream, TUSER marks start of frame (pixel 0,0)
//   pixel_out_*  : cropped stream, TUSER on first cropped pixel, TLAST on
//                  last pixel of each cropped row
//   cfg_*        : frame size and crop window, latched on each SOF beat
//   cfg_error    : latched config was invalid (held until next SOF)
//   frame_done   : one-cycle pulse after the last pixel of a frame
// ----------------------------------------------------------------------------
module crop_roi_stream
    import crop_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH = 12,
    parameter int CHANNELS        = 1,
    parameter int MAX_ROWS        = DEFAULT_MAX_ROWS,
    parameter int MAX_COLS        = DEFAULT_MAX_COLS,
    parameter int FIFO_DEPTH      = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [PIXEL_BIT_WIDTH*CHANNELS-1:0]   pixel_in_TDATA,
    input  logic                                  pixel_in_TVALID,
    output logic                                  pixel_in_TREADY,
    input  logic                                  pixel_in_TUSER,
    output logic [PIXEL_BIT_WIDTH*CHANNELS-1:0]   pixel_out_TDATA,
    output logic                                  pixel_out_TVALID,
    input  logic                                  pixel_out_TREADY,
    output logic                                  pixel_out_TUSER,
    output logic                                  pixel_out_TLAST,
    input  logic [cnt_width(MAX_ROWS)-1:0]        cfg_in_rows,
    input  logic [cnt_width(MAX_ROWS)-1:0]        cfg_y1,
    input  logic [cnt_width(MAX_ROWS)-1:0]        cfg_out_rows,
    input  logic [cnt_width(MAX_COLS)-1:0]        cfg_in_cols,
    input  logic [cnt_width(MAX_COLS)-1:0]        cfg_x1,
    input  logic [cnt_width(MAX_COLS)-1:0]        cfg_out_cols,
    output logic                                  cfg_error,
    output logic                                  frame_done
);

    localparam int ROW_BITS = cnt_width(MAX_ROWS);
    localparam int COL_BITS = cnt_width(MAX_COLS);
    localparam int DW       = PIXEL_BIT_WIDTH * CHANNELS;

    crop_state_t         state_reg, state_next;
    logic [ROW_BITS-1:0] row_reg, row_next;
    logic [COL_BITS-1:0] col_reg, col_next;
    logic [ROW_BITS-1:0] in_rows_reg, in_rows_next;
    logic [ROW_BITS-1:0] y1_reg, y1_next;
    logic [ROW_BITS-1:0] out_rows_reg, out_rows_next;
    logic [COL_BITS-1:0] in_cols_reg, in_cols_next;
    logic [COL_BITS-1:0] x1_reg, x1_next;
    logic [COL_BITS-1:0] out_cols_reg, out_cols_next;
    logic                cfg_error_reg, cfg_error_next;
    logic                frame_done_reg, frame_done_next;

    // Effective view for the current beat: an SOF beat uses the config on
    // the ports and position (0,0) as if they were already latched.
    logic                accept, sof, cfg_ok, counting, frame_end;
    crop_state_t         eff_state;
    logic [ROW_BITS-1:0] e_row, e_in_rows, e_y1, e_out_rows;
    logic [COL_BITS-1:0] e_col, e_in_cols, e_x1, e_out_cols;
    logic [ROW_BITS:0]   cfg_y_end, y_end;
    logic [COL_BITS:0]   cfg_x_end, x_end;
    logic                in_win, col_wrap, row_last;

    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [DW+1:0]       fifo_wr_data, fifo_rd_data;

    always_comb begin
        state_next      = state_reg;
        row_next        = row_reg;
        col_next        = col_reg;
        in_rows_next    = in_rows_reg;
        y1_next         = y1_reg;
        out_rows_next   = out_rows_reg;
        in_cols_next    = in_cols_reg;
        x1_next         = x1_reg;
        out_cols_next   = out_cols_reg;
        cfg_error_next  = cfg_error_reg;
        frame_done_next = 1'b0;

        accept = pixel_in_TVALID && pixel_in_TREADY;
        sof    = accept && pixel_in_TUSER;

        // Sums are one bit wider than the operands so they never wrap.
        cfg_y_end = {1'b0, cfg_y1} + {1'b0, cfg_out_rows};
        cfg_x_end = {1'b0, cfg_x1} + {1'b0, cfg_out_cols};
        cfg_ok    = (cfg_out_rows != '0) && (cfg_out_cols != '0) &&
                    (cfg_y_end <= {1'b0, cfg_in_rows}) &&
                    (cfg_x_end <= {1'b0, cfg_in_cols}) &&
                    (cfg_in_rows <= ROW_BITS'(MAX_ROWS)) &&
                    (cfg_in_cols <= COL_BITS'(MAX_COLS));

        e_in_rows  = sof ? cfg_in_rows  : in_rows_reg;
        e_y1       = sof ? cfg_y1       : y1_reg;
        e_out_rows = sof ? cfg_out_rows : out_rows_reg;
        e_in_cols  = sof ? cfg_in_cols  : in_cols_reg;
        e_x1       = sof ? cfg_x1       : x1_reg;
        e_out_cols = sof ? cfg_out_cols : out_cols_reg;
        e_row      = sof ? '0 : row_reg;
        e_col      = sof ? '0 : col_reg;
        eff_state  = sof ? (cfg_ok ? RUN : SKIP) : state_reg;

        y_end  = {1'b0, e_y1} + {1'b0, e_out_rows};
        x_end  = {1'b0, e_x1} + {1'b0, e_out_cols};
        in_win = (e_row >= e_y1) && ({1'b0, e_row} < y_end) &&
                 (e_col >= e_x1) && ({1'b0, e_col} < x_end);

        counting  = accept && (eff_state != IDLE);
        col_wrap  = (e_col == e_in_cols - COL_BITS'(1));
        row_last  = (e_row == e_in_rows - ROW_BITS'(1));
        frame_end = counting && col_wrap && row_last;

        fifo_push    = counting && (eff_state == RUN) && in_win;
        fifo_wr_data = {pixel_in_TDATA,
                        (e_row == e_y1) && (e_col == e_x1),
                        {1'b0, e_col} == x_end - (COL_BITS+1)'(1)};

        if (sof) begin
            in_rows_next   = cfg_in_rows;
            y1_next        = cfg_y1;
            out_rows_next  = cfg_out_rows;
            in_cols_next   = cfg_in_cols;
            x1_next        = cfg_x1;
            out_cols_next  = cfg_out_cols;
            cfg_error_next = !cfg_ok;
        end

        if (counting) begin
            state_next = eff_state;
            if (frame_end) begin
                state_next      = IDLE;
                row_next        = '0;
                col_next        = '0;
                frame_done_next = 1'b1;
            end else if (col_wrap) begin
                col_next = '0;
                row_next = e_row + ROW_BITS'(1);
            end else begin
                col_next = e_col + COL_BITS'(1);
                row_next = e_row;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            row_reg        <= '0;
            col_reg        <= '0;
            in_rows_reg    <= '0;
            y1_reg         <= '0;
            out_rows_reg   <= '0;
            in_cols_reg    <= '0;
            x1_reg         <= '0;
            out_cols_reg   <= '0;
            cfg_error_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            row_reg        <= row_next;
            col_reg        <= col_next;
            in_rows_reg    <= in_rows_next;
            y1_reg         <= y1_next;
            out_rows_reg   <= out_rows_next;
            in_cols_reg    <= in_cols_next;
            x1_reg         <= x1_next;
            out_cols_reg   <= out_cols_next;
            cfg_error_reg  <= cfg_error_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Only RUN can push, so only RUN needs to respect buffer space.
    assign pixel_in_TREADY = reset && ((state_reg != RUN) || !fifo_full);

    assign fifo_pop = reset && pixel_out_TREADY && !fifo_empty;

    fifo_sync #(
        .DATA_WIDTH (DW + 2),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_push),
        .wr_data (fifo_wr_data),
        .full    (fifo_full),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty)
    );

    // Outputs are forced low during reset, before the clock has cleared state.
    assign pixel_out_TVALID = reset && !fifo_empty;
    assign pixel_out_TDATA  = fifo_rd_data[DW+1:2];
    assign pixel_out_TUSER  = reset && !fifo_empty && fifo_rd_data[1];
    assign pixel_out_TLAST  = reset && !fifo_empty && fifo_rd_data[0];
    assign cfg_error        = reset && cfg_error_reg;
    assign frame_done       = reset && frame_done_reg;

endmodule

// File: tb/tb_crop_roi_stream.sv
// ----------------------------------------------------------------------------
// tb_crop_roi_stream
// Directed bench for crop_roi_stream (8-bit x 3 channels, 16x16 max frame,
// 4-entry output buffer). A frame-level model turns every accepted input beat
// into its expected output beat; one compare process checks each output
// handshake against it, plus literal expectations per scenario.
// ----------------------------------------------------------------------------
module tb_crop_roi_stream;

    localparam int PW    = 8;
    localparam int CH    = 3;
    localparam int DW    = PW * CH;
    localparam int RW    = 5;
    localparam int CW    = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_user = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_user;
    logic          out_last;
    logic [RW-1:0] cfg_in_rows = '0, cfg_y1 = '0, cfg_out_rows = '0;
    logic [CW-1:0] cfg_in_cols = '0, cfg_x1 = '0, cfg_out_cols = '0;
    logic          cfg_error;
    logic          frame_done;

    crop_roi_stream #(
        .PIXEL_BIT_WIDTH (PW),
        .CHANNELS        (CH),
        .MAX_ROWS        (16),
        .MAX_COLS        (16),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pixel_in_TDATA   (in_data),
        .pixel_in_TVALID  (in_valid),
        .pixel_in_TREADY  (in_ready),
        .pixel_in_TUSER   (in_user),
        .pixel_out_TDATA  (out_data),
        .pixel_out_TVALID (out_valid),
        .pixel_out_TREADY (out_ready),
        .pixel_out_TUSER  (out_user),
        .pixel_out_TLAST  (out_last),
        .cfg_in_rows      (cfg_in_rows),
        .cfg_y1           (cfg_y1),
        .cfg_out_rows     (cfg_out_rows),
        .cfg_in_cols      (cfg_in_cols),
        .cfg_x1           (cfg_x1),
        .cfg_out_cols     (cfg_out_cols),
        .cfg_error        (cfg_error),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int passes = 0;

    // Model state and logs
    beat_t         exp_q[$];
    int            got_ch0[$];
    logic          got_u[$];
    logic          got_l[$];
    logic [DW-1:0] got_data[$];
    int            done_cycle = -1;
    int            done_pulses = 0;
    int            stall_cycles = 0;
    int            ready_mode = 0;   // 0 always ready, 1 never, 2 pattern
    int            m_state = 0;      // 0 idle, 1 cropping, 2 invalid config
    int            m_k = 0;
    int            m_rows, m_cols, m_y1, m_x1, m_orows, m_ocols;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] pix(input int k);
        logic [7:0] c0, c1, c2;
        c0 = 8'(k);
        c1 = 8'(k + 100);
        c2 = 8'(255 - k);
        return {c2, c1, c0};
    endfunction

    // Frame-level model: the beat index inside the frame gives (row, col)
    // by division; the crop rectangle decides what must come out.
    task automatic model_beat(input logic [DW-1:0] d, input logic u);
        int r, c;
        beat_t b;
        if (u) begin
            m_rows  = int'(cfg_in_rows);
            m_cols  = int'(cfg_in_cols);
            m_y1    = int'(cfg_y1);
            m_x1    = int'(cfg_x1);
            m_orows = int'(cfg_out_rows);
            m_ocols = int'(cfg_out_cols);
            m_k     = 0;
            m_state = (m_orows > 0 && m_ocols > 0 && m_y1 + m_orows <= m_rows &&
                       m_x1 + m_ocols <= m_cols && m_rows <= 16 && m_cols <= 16) ? 1 : 2;
        end else if (m_state == 0) begin
            return;
        end
        if (m_state == 1) begin
            r = m_k / m_cols;
            c = m_k % m_cols;
            if (r >= m_y1 && r < m_y1 + m_orows && c >= m_x1 && c < m_x1 + m_ocols) begin
                b.d = d;
                b.u = (r == m_y1) && (c == m_x1);
                b.l = (c == m_x1 + m_ocols - 1);
                exp_q.push_back(b);
            end
        end
        if (m_k == m_rows * m_cols - 1) begin
            m_state    = 0;
            done_cycle = cycle + 1;
        end
        m_k++;
    endtask

    // Present one beat; it is accepted at the first rising edge where the
    // preceding falling edge saw TREADY high.
    task automatic send_beat(input logic [DW-1:0] d, input logic u);
        int waited;
        waited = 0;
        @(posedge clk);
        #1;
        in_data  = d;
        in_user  = u;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stall_cycles++;
            waited++;
            if (waited > 200) begin
                check("in_ready_timeout", 1'b0, 1'b1);
                in_valid = 1'b0;
                return;
            end
        end
        model_beat(d, u);
    endtask

    task automatic send_frame(input int rows, input int cols, input int y1, input int x1,
                              input int orows, input int ocols, input int n, input int start);
        cfg_in_rows  = RW'(rows);
        cfg_in_cols  = CW'(cols);
        cfg_y1       = RW'(y1);
        cfg_x1       = CW'(x1);
        cfg_out_rows = RW'(orows);
        cfg_out_cols = CW'(ocols);
        for (int k = 0; k < n; k++) send_beat(pix(start + k), k == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_user  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_logs();
        got_ch0.delete();
        got_u.delete();
        got_l.delete();
        got_data.delete();
        done_pulses  = 0;
        stall_cycles = 0;
    endtask

    // Output-ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 :
                        (ready_mode == 1) ? 1'b0 : ((cycle % 3) != 0);
        end
    end

    // Compare process: every cycle
    initial begin
        beat_t e;
        beat_t prev;
        logic  prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("rst_out_valid", out_valid, 1'b0);
                check("rst_out_user", out_user, 1'b0);
                check("rst_out_last", out_last, 1'b0);
                check("rst_in_ready", in_ready, 1'b0);
                check("rst_cfg_error", cfg_error, 1'b0);
                check("rst_frame_done", frame_done, 1'b0);
                prev_stall = 1'b0;
            end else begin
                check("frame_done", frame_done, cycle == done_cycle);
                if (frame_done) done_pulses++;
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_data", {out_data, out_user, out_last}, prev);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out_beat", out_data, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.d);
                        check("out_user", out_user, e.u);
                        check("out_last", out_last, e.l);
                    end
                    got_ch0.push_back(int'(out_data[7:0]));
                    got_u.push_back(out_user);
                    got_l.push_back(out_last);
                    got_data.push_back(out_data);
                end
                prev_stall = out_valid && !out_ready;
                prev = {out_data, out_user, out_last};
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_basic[12] = '{19, 20, 21, 22, 27, 28, 29, 30, 35, 36, 37, 38};
        int exp_mid[5]    = '{19, 20, 21, 24, 25};
        logic exp_mid_u[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic exp_mid_l[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);

        // Basic crop: 8x8, y1=2 x1=3, 3x4
        clear_logs();
        send_frame(8, 8, 2, 3, 3, 4, 64, 0);
        drain();
        check("basic_count", got_ch0.size(), 12);
        if (got_ch0.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                check($sformatf("basic_val%0d", i), got_ch0[i], exp_basic[i]);
                check($sformatf("basic_user%0d", i), got_u[i], i == 0);
                check($sformatf("basic_last%0d", i), got_l[i], (i % 4) == 3);
            end
        end
        check("basic_done_pulses", done_pulses, 1);
        check("basic_cfg_error", cfg_error, 1'b0);

        // Backpressure: 2x8 frame, crop row 0 (1x8), output stalled 20 cycles
        clear_logs();
        ready_mode = 1;
        fork
            send_frame(2, 8, 0, 0, 1, 8, 16, 0);
            begin
                repeat (20) @(negedge clk);
                check("bp_in_ready_low", in_ready, 1'b0);
                check("bp_pushes", exp_q.size(), 4);
                check("bp_out_valid", out_valid, 1'b1);
                ready_mode = 0;
            end
        join
        drain();
        check("bp_count", got_ch0.size(), 8);
        if (got_ch0.size() == 8) begin
            for (int i = 0; i < 8; i++) check($sformatf("bp_val%0d", i), got_ch0[i], i);
            check("bp_last", got_l[7], 1'b1);
        end

        // Invalid config: y1=6 + 3 rows > 8
        clear_logs();
        send_frame(8, 8, 6, 0, 3, 4, 64, 0);
        drain();
        check("inv_cfg_error", cfg_error, 1'b1);
        check("inv_no_stall", stall_cycles, 0);
        check("inv_no_output", got_ch0.size(), 0);
        check("inv_done_pulses", done_pulses, 1);

        // Mid-frame SOF at beat 20 with a new 4x4 config cropping 2x2 at origin
        clear_logs();
        ready_mode = 2;
        send_frame(8, 8, 2, 3, 3, 4, 20, 0);
        send_frame(4, 4, 0, 0, 2, 2, 16, 20);
        drain();
        ready_mode = 0;
        check("mid_cfg_error", cfg_error, 1'b0);
        check("mid_count", got_ch0.size(), 5);
        if (got_ch0.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("mid_val%0d", i), got_ch0[i], exp_mid[i]);
                check($sformatf("mid_user%0d", i), got_u[i], exp_mid_u[i]);
                check($sformatf("mid_last%0d", i), got_l[i], exp_mid_l[i]);
            end
        end
        check("mid_done_pulses", done_pulses, 1);

        // Reset mid-frame at beat 30 with 27,28,29 buffered
        clear_logs();
        ready_mode = 1;
        send_frame(8, 8, 3, 3, 1, 5, 30, 0);
        check("rstmid_buffered", exp_q.size(), 3);
        check("rstmid_valid_before", out_valid, 1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rstmid_valid_after", out_valid, 1'b0);
        exp_q.delete();
        m_state = 0;
        done_cycle = -1;
        @(posedge clk);
        #1 reset = 1'b1;
        ready_mode = 0;
        for (int k = 30; k < 40; k++) send_beat(pix(k), 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rstmid_no_output", got_ch0.size(), 0);
        check("rstmid_out_valid", out_valid, 1'b0);

        // Multi-channel full-frame crop 4x4
        clear_logs();
        send_frame(4, 4, 0, 0, 4, 4, 16, 50);
        drain();
        check("mc_count", got_data.size(), 16);
        if (got_data.size() == 16) begin
            check("mc_first", got_data[0], 24'hCD9632);
            check("mc_last", got_data[15], 24'hBEA541);
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
